// File: rtl/communication_send_if.sv
// communication_send_if: local byte handshake plus the serial link pins toward FPGA2
interface communication_send_if;
  logic       send_en;
  logic       en;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       send_data;
  logic       freq;
  logic       busy;
  logic       done;
  modport slave (input send_en, en, tx_valid, tx_data, output tx_ready, send_data, freq, busy, done);
  modport master (output send_en, en, tx_valid, tx_data, input tx_ready, send_data, freq, busy, done);
endinterface

// File: rtl/communication_send.sv
// communication_send: serialises bytes (start, MSB-first data, stop) with a forwarded bit clock
module communication_send #(
  parameter int CLK_DIV     = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  communication_send_if.slave bus
);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(2 * CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, WAIT_EN, SHIFT, GAP} state_t;
  state_t                 state, state_n;
  logic [7:0]             shreg, shreg_n;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   line, line_n, freq_r, freq_n, done_r, done_n;
  logic [SYNC_STAGES-1:0] en_sh, send_en_sh;
  logic                   en_sync, send_en_sync, xfer;
  assign en_sync      = en_sh[SYNC_STAGES-1];
  assign send_en_sync = send_en_sh[SYNC_STAGES-1];
  assign bus.tx_ready = (state == IDLE) && send_en_sync;
  assign bus.busy     = state != IDLE;
  assign bus.send_data = line;
  assign bus.freq     = freq_r;
  assign bus.done     = done_r;
  assign xfer         = bus.tx_valid && bus.tx_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      cnt        <= '0;
      line       <= 1'b1;
      freq_r     <= 1'b0;
      done_r     <= 1'b0;
      en_sh      <= '0;
      send_en_sh <= '0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      cnt        <= cnt_n;
      line       <= line_n;
      freq_r     <= freq_n;
      done_r     <= done_n;
      en_sh      <= SYNC_STAGES'({en_sh, bus.en});
      send_en_sh <= SYNC_STAGES'({send_en_sh, bus.send_en});
    end
  end
  // Ones are shifted in behind the data so shreg[7] is already the stop bit after bit 8
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    cnt_n     = cnt;
    line_n    = line;
    freq_n    = freq_r;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        line_n = 1'b1;
        freq_n = 1'b0;
        if (xfer) begin
          state_n = WAIT_EN;
          shreg_n = bus.tx_data;
        end
      end
      WAIT_EN: if (en_sync) begin
        state_n   = SHIFT;
        line_n    = 1'b0;
        freq_n    = 1'b0;
        bit_cnt_n = '0;
        cnt_n     = '0;
      end
      SHIFT: if (cnt == HALF_END) begin
        cnt_n  = '0;
        freq_n = ~freq_r;
        if (freq_r && bit_cnt == 4'd9) begin
          state_n = GAP;
          line_n  = 1'b1;
          freq_n  = 1'b0;
          done_n  = 1'b1;
        end else if (freq_r) begin
          bit_cnt_n = bit_cnt + 4'd1;
          line_n    = shreg[7];
          shreg_n   = {shreg[6:0], 1'b1};
        end
      end else cnt_n = cnt + 1'b1;
      GAP: begin
        cnt_n   = cnt == GAP_END ? '0 : cnt + 1'b1;
        state_n = cnt == GAP_END ? IDLE : GAP;
      end
    endcase
  end
endmodule

// File: tb/tb_communication_send.sv
// tb_communication_send: table-driven frames plus flow-control, gating, reset and back-to-back sequences
module tb_communication_send;
  localparam int CD       = 4;
  localparam int DONE_LAT = 20 * CD + 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  communication_send_if bus();
  communication_send #(.CLK_DIV(CD), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  int         n_chk = 0, n_fail = 0, n_frames = 0;
  logic [9:0] frame, last_frame;
  logic       rx_on = 1'b0, f_prev = 1'b0;
  int         t = 0, nb = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // Scoreboard push on accept plus a receiver model that samples on freq rising edges
  always @(negedge clk) begin
    if (!rst) begin
      rx_on = 1'b0;
      nb = 0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) exp_q.push_back(bus.tx_data);
      if (rx_on) t++;
      if (!rx_on && !bus.send_data) begin
        rx_on = 1'b1;
        t = 0;
        nb = 0;
      end
      if (rx_on && bus.freq && !f_prev) begin
        chk("bit_timing", 32'(t), 32'(CD + 2 * CD * nb));
        frame[9-nb] = bus.send_data;
        nb++;
        if (nb == 10) begin
          rx_on = 1'b0;
          last_frame = frame;
          n_frames++;
          chk("start_bit", 32'(frame[9]), 0);
          chk("stop_bit", 32'(frame[0]), 1);
          chk("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("rx_byte", 32'(frame[8:1]), 32'(exp_q.pop_front()));
        end
      end
    end
    f_prev = bus.freq;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    while (!bus.tx_ready && n < 200) begin
      tick(1);
      n++;
    end
    chk("accept_in_time", 32'(n < 200), 1);
    tick(1);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!bus.done && n < 400);
    chk("done_seen", 32'(bus.done), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, nf0;
    logic ok;
    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h3C, 10'b0001111001};
    vecs[2] = '{8'h00, 10'b0000000001};
    vecs[3] = '{8'hFF, 10'b0111111111};
    vecs[4] = '{8'h5A, 10'b0010110101};
    vecs[5] = '{8'h81, 10'b0100000011};
    bus.send_en = 1'b1;
    bus.en = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    tick(3);
    chk("rst_send_data", 32'(bus.send_data), 1);
    chk("rst_freq", 32'(bus.freq), 0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    rst = 1'b1;
    tick(3);
    for (int i = 0; i < 6; i++) begin
      send_byte(vecs[i].data);
      chk("busy_after_accept", 32'(bus.busy), 1);
      wait_done(n);
      chk("done_latency", 32'(n), 32'(DONE_LAT));
      chk("line_at_done", 32'(bus.send_data), 1);
      chk("freq_at_done", 32'(bus.freq), 0);
      chk("frame_bits", 32'(last_frame), 32'(vecs[i].frame));
      ok = 1'b1;
      for (int k = 0; k < 2 * CD - 1; k++) begin
        tick(1);
        ok &= !bus.tx_ready && bus.busy && !bus.done && bus.send_data;
      end
      chk("gap_held", 32'(ok), 1);
      tick(1);
      chk("ready_after_gap", 32'(bus.tx_ready), 1);
      chk("idle_after_gap", 32'(bus.busy), 0);
    end
    bus.en = 1'b0;
    tick(4);
    send_byte(8'h3C);
    ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      ok &= bus.send_data && !bus.freq && bus.busy;
    end
    chk("wait_en_hold", 32'(ok), 1);
    bus.en = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (bus.send_data && n < 50);
    chk("en_to_start", 32'(n), 3);
    wait_done(n);
    tick(2 * CD + 1);
    bus.send_en = 1'b0;
    tick(4);
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h96;
    nf0 = n_frames;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      ok &= !bus.tx_ready && !bus.busy;
    end
    chk("gated_no_ready", 32'(ok), 1);
    bus.send_en = 1'b1;
    tick(1);
    chk("gate_ready_1clk", 32'(bus.tx_ready), 0);
    tick(1);
    chk("gate_ready_2clk", 32'(bus.tx_ready), 1);
    tick(1);
    bus.tx_valid = 1'b0;
    chk("gate_accepted", 32'(bus.busy), 1);
    wait_done(n);
    chk("gate_frame_count", 32'(n_frames), 32'(nf0 + 1));
    tick(2 * CD + 1);
    send_byte(8'hFF);
    tick(36);
    bus.send_en = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h42;
    wait_done(n);
    chk("drop_frame", 32'(last_frame), 32'(10'b0111111111));
    nf0 = n_frames;
    ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick(1);
      ok &= !bus.tx_ready;
    end
    chk("drop_no_ready", 32'(ok), 1);
    chk("drop_idle", 32'(bus.busy), 0);
    chk("drop_no_frame", 32'(n_frames), 32'(nf0));
    bus.tx_valid = 1'b0;
    bus.send_en = 1'b1;
    tick(3);
    send_byte(8'hC3);
    tick(54);
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_send_data", 32'(bus.send_data), 1);
    chk("midrst_freq", 32'(bus.freq), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    tick(3);
    rst = 1'b1;
    nf0 = n_frames;
    send_byte(8'h00);
    wait_done(n);
    chk("post_rst_frame", 32'(last_frame), 32'(10'b0000000001));
    chk("post_rst_count", 32'(n_frames), 32'(nf0 + 1));
    tick(2 * CD + 1);
    nf0 = n_frames;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h01;
    n = 0;
    while (!bus.tx_ready && n < 50) begin
      tick(1);
      n++;
    end
    tick(1);
    bus.tx_data = 8'h80;
    wait_done(n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (bus.send_data && n < 100);
    bus.tx_valid = 1'b0;
    chk("b2b_gap_ge8", 32'(n >= 2 * CD), 1);
    wait_done(n);
    chk("b2b_frame_count", 32'(n_frames), 32'(nf0 + 2));
    chk("b2b_last_frame", 32'(last_frame), 32'(10'b0100000001));
    tick(20);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
